// File: rtl/flex_countdown_timer_pkg.sv
// Shared types for the flex countdown timer slice.
// Build option: FLEX_TIMER_AUTO_RELOAD_EN selects periodic reload at expiry.
package flex_timer_pkg;

  typedef enum logic [0:0] {
    TMR_IDLE = 1'b0,
    TMR_RUN  = 1'b1
  } timer_state_t;

  localparam int DEF_NUM_CNT_BITS  = 4;
  localparam int DEF_PRESCALE_BITS = 4;

endpackage

// File: rtl/flex_countdown_timer_if.sv
// Control/status bundle of the flex countdown timer; the master drives the controls.
interface flex_countdown_timer_if #(
  parameter int NUM_CNT_BITS  = 4,
  parameter int PRESCALE_BITS = 4
);

  logic                     clear;
  logic                     start;
  logic                     pause;
  logic [NUM_CNT_BITS-1:0]  load_val;
  logic [PRESCALE_BITS-1:0] prescale_val;
  logic [NUM_CNT_BITS-1:0]  count_out;
  logic                     busy;
  logic                     done;
  logic                     expired_flag;

  modport master (
    output clear, start, pause, load_val, prescale_val,
    input  count_out, busy, done, expired_flag
  );

  modport slave (
    input  clear, start, pause, load_val, prescale_val,
    output count_out, busy, done, expired_flag
  );

endinterface

// File: rtl/flex_countdown_timer_prescaler.sv
// Tick divider: one tick every (prescale_val+1) enabled cycles; tick decodes the count register.
module tick_prescaler #(
  parameter int PRESCALE_BITS = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     enable,
  input  logic [PRESCALE_BITS-1:0] prescale_val,
  output logic                     tick
);

  localparam logic [PRESCALE_BITS-1:0] PRE_ZERO = {PRESCALE_BITS{1'b0}};
  localparam logic [PRESCALE_BITS-1:0] PRE_ONE  = {{(PRESCALE_BITS-1){1'b0}}, 1'b1};

  logic [PRESCALE_BITS-1:0] cnt_r;

  // Prescale counter: cleared by start/clear, holds while disabled, wraps at prescale_val
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_r <= PRE_ZERO;
    end else if (clear) begin
      cnt_r <= PRE_ZERO;
    end else if (enable) begin
      if (cnt_r == prescale_val) begin
        cnt_r <= PRE_ZERO;
      end else begin
        cnt_r <= cnt_r + PRE_ONE;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = enable & (cnt_r == prescale_val);

endmodule

// File: rtl/flex_countdown_timer.sv
// Loadable down-counting timer with prescaled ticks, 1-cycle done pulse and sticky expiry.
// Build option: FLEX_TIMER_AUTO_RELOAD_EN reloads from live load_val at expiry (periodic mode).
module flex_countdown_timer
  import flex_timer_pkg::*;
#(
  parameter int NUM_CNT_BITS  = DEF_NUM_CNT_BITS,
  parameter int PRESCALE_BITS = DEF_PRESCALE_BITS
) (
  input  logic                  clk,
  input  logic                  n_rst,
  flex_countdown_timer_if.slave bus
);

  localparam logic [NUM_CNT_BITS-1:0]  CNT_ZERO = {NUM_CNT_BITS{1'b0}};
  localparam logic [NUM_CNT_BITS-1:0]  CNT_ONE  = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_BITS-1:0] PRE_ZERO = {PRESCALE_BITS{1'b0}};

  timer_state_t             state_r, state_s;
  logic [NUM_CNT_BITS-1:0]  count_r, count_s;
  logic                     done_r, done_s;
  logic                     exp_r, exp_s;
  logic                     busy_r, busy_s;
  logic [PRESCALE_BITS-1:0] presc_cap_r;
  logic                     tick_s;
  logic                     presc_clr_s;
  logic                     presc_en_s;

  // A start (or clear) also restarts the divider so the first tick lands a full period later
  assign presc_clr_s = bus.start | bus.clear;
  assign presc_en_s  = busy_r & ~bus.pause;

  tick_prescaler #(
    .PRESCALE_BITS (PRESCALE_BITS)
  ) u_prescaler (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (presc_clr_s),
    .enable       (presc_en_s),
    .prescale_val (presc_cap_r),
    .tick         (tick_s)
  );

  // Divider setting is held stable for the whole run, captured only on an accepted start
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      presc_cap_r <= PRE_ZERO;
    end else if (bus.start && !bus.clear) begin
      presc_cap_r <= bus.prescale_val;
    end else begin
      presc_cap_r <= presc_cap_r;
    end
  end

  // Next-state: clear > start > tick; pause acts through the prescaler enable
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    done_s  = 1'b0;
    exp_s   = exp_r;
    if (bus.clear) begin
      state_s = TMR_IDLE;
      count_s = CNT_ZERO;
      exp_s   = 1'b0;
    end else if (bus.start) begin
      count_s = bus.load_val;
      exp_s   = 1'b0;
      if (bus.load_val == CNT_ZERO) begin
        state_s = TMR_IDLE;
        done_s  = 1'b1;
        exp_s   = 1'b1;
      end else begin
        state_s = TMR_RUN;
      end
    end else if (tick_s && (state_r == TMR_RUN)) begin
      // <= guards against ever wrapping below zero
      if (count_r <= CNT_ONE) begin
        done_s = 1'b1;
        exp_s  = 1'b1;
`ifdef FLEX_TIMER_AUTO_RELOAD_EN
        if (bus.load_val != CNT_ZERO) begin
          count_s = bus.load_val;
          state_s = TMR_RUN;
        end else begin
          count_s = CNT_ZERO;
          state_s = TMR_IDLE;
        end
`else
        count_s = CNT_ZERO;
        state_s = TMR_IDLE;
`endif
      end else begin
        count_s = count_r - CNT_ONE;
      end
    end else begin
      state_s = state_r;
    end
    busy_s = (state_s == TMR_RUN);
  end

  // State and output registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= TMR_IDLE;
      count_r <= CNT_ZERO;
      done_r  <= 1'b0;
      exp_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      done_r  <= done_s;
      exp_r   <= exp_s;
      busy_r  <= busy_s;
    end
  end

  assign bus.count_out    = count_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.expired_flag = exp_r;

endmodule

// File: tb/tb_flex_countdown_timer.sv
// Randomized and directed bench for flex_countdown_timer against a cycle-level behavioural model.
module tb_flex_countdown_timer;

  logic clk;
  logic n_rst;
  int   n_tests;
  int   n_fail;

  // model: remaining count, cycles left until next tick, divider period
  bit   m_run;
  int   m_cnt;
  int   m_left;
  int   m_period;
  bit   m_done;
  bit   m_exp;

  flex_countdown_timer_if #(.NUM_CNT_BITS(4), .PRESCALE_BITS(4)) bus ();

  flex_countdown_timer #(
    .NUM_CNT_BITS  (4),
    .PRESCALE_BITS (4)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_cnt = 0; m_left = 0; m_period = 1; m_done = 1'b0; m_exp = 1'b0;
  endtask

  task automatic model_update();
    m_done = 1'b0;
    if (!n_rst) begin
      model_reset();
    end else if (bus.clear) begin
      m_run = 1'b0; m_cnt = 0; m_exp = 1'b0;
    end else if (bus.start) begin
      m_cnt    = int'(bus.load_val);
      m_period = int'(bus.prescale_val) + 1;
      m_left   = m_period;
      m_exp    = 1'b0;
      if (m_cnt == 0) begin
        m_run = 1'b0; m_done = 1'b1; m_exp = 1'b1;
      end else begin
        m_run = 1'b1;
      end
    end else if (m_run && !bus.pause) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_left = m_period;
        if (m_cnt == 1) begin
          m_done = 1'b1; m_exp = 1'b1;
`ifdef FLEX_TIMER_AUTO_RELOAD_EN
          m_cnt = int'(bus.load_val);
          m_run = (m_cnt != 0);
`else
          m_cnt = 0;
          m_run = 1'b0;
`endif
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_cnt"},  int'(bus.count_out),    m_cnt);
    chk({tag, "_busy"}, int'(bus.busy),         int'(m_run));
    chk({tag, "_done"}, int'(bus.done),         int'(m_done));
    chk({tag, "_exp"},  int'(bus.expired_flag), int'(m_exp));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_update();
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    bus.clear = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
  endtask

  // start at edge E0, then count edges until done; optional pause window by edge index
  task automatic run_to_done(input string tag, input int load, input int presc,
                             input int pause_from, input int pause_len,
                             input int budget, output int n);
    bus.load_val = 4'(load); bus.prescale_val = 4'(presc); bus.start = 1'b1;
    step(tag);
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < budget) begin
      bus.pause = (n + 1 >= pause_from) && (n + 1 < pause_from + pause_len);
      step(tag);
      n++;
    end
    bus.pause = 1'b0;
    if (n >= budget) chk({tag, "_timeout"}, 1, 0);
  endtask

  initial begin
    int n;
    int dones;
    n_tests = 0; n_fail = 0;
    model_reset();
    idle_inputs();
    bus.load_val = 4'd0; bus.prescale_val = 4'd0;
    n_rst = 1'b0;
    #2;
    check_outputs("reset");
    #10 n_rst = 1'b1;
    step("idle");

    // basic countdown, divided countdown, paused countdown
    run_to_done("t1", 5, 0, 0, 0, 40, n);
    chk("t1_latency", n, 5);
    step("t1_after");
    run_to_done("t2", 3, 2, 0, 0, 40, n);
    chk("t2_latency", n, 9);
    run_to_done("t3", 6, 0, 3, 4, 40, n);
    chk("t3_latency", n, 10);

    // start and clear together mid-run, then a zero-length start
    bus.load_val = 4'd7; bus.prescale_val = 4'd1; bus.start = 1'b1;
    step("t4_start");
    bus.start = 1'b0;
    repeat (3) step("t4_run");
    bus.start = 1'b1; bus.clear = 1'b1;
    step("t4_both");
    idle_inputs();
    repeat (3) step("t4_post");
    bus.load_val = 4'd0; bus.start = 1'b1;
    step("t4_zero");
    bus.start = 1'b0;
    repeat (2) step("t4_zero_post");

    // asynchronous reset mid-run at count 3
    bus.load_val = 4'd9; bus.prescale_val = 4'd0; bus.start = 1'b1;
    step("t5_start");
    bus.start = 1'b0;
    n = 0;
    while (m_cnt != 3 && n < 20) begin step("t5_run"); n++; end
    n_rst = 1'b0;
    #1;
    model_reset();
    check_outputs("t5_async");
    step("t5_held");
    n_rst = 1'b1;
    run_to_done("t5_restart", 2, 1, 0, 0, 40, n);
    chk("t5_latency", n, 4);

`ifdef FLEX_TIMER_AUTO_RELOAD_EN
    bus.load_val = 4'd3; bus.prescale_val = 4'd0; bus.start = 1'b1;
    step("t6_start");
    bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 9; i++) begin step("t6_periodic"); dones += int'(bus.done); end
    chk("t6_dones", dones, 3);
    bus.load_val = 4'd0;
    repeat (4) step("t6_stop");
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.clear        = ($urandom_range(0, 49) == 0);
      bus.start        = ($urandom_range(0, 15) == 0);
      bus.pause        = ($urandom_range(0, 4) == 0);
      bus.load_val     = 4'($urandom_range(0, 15));
      bus.prescale_val = 4'($urandom_range(0, 3));
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
